// File: rtl/uart_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : uart_tx_if                                                  |
// | Purpose  : Request/serial bundle between a frame source and uart_tx.   |
// | Signals  : p_data     - parallel payload (DATA_WIDTH bits)             |
// |            data_valid - single-cycle send request                      |
// |            par_en     - append parity bit when 1                       |
// |            par_typ    - parity type, 0 = even, 1 = odd                 |
// |            prescale   - clk cycles per serial bit (0 behaves as 1)     |
// |            tx_out     - serial line, idle high                         |
// |            busy       - high while a frame is in progress              |
// | Modports : master (frame source), slave (uart_tx)                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic [PRESCALE_W-1:0] prescale;
   logic                  tx_out;
   logic                  busy;

   modport master (
      output p_data, data_valid, par_en, par_typ, prescale,
      input  tx_out, busy
   );

   modport slave (
      input  p_data, data_valid, par_en, par_typ, prescale,
      output tx_out, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : uart_tx                                                     |
// | Purpose  : Serial transmitter: start bit, DATA_WIDTH data bits LSB     |
// |            first, optional parity bit, stop bit. Each bit lasts        |
// |            'prescale' clk cycles (prescale latched per frame).         |
// | Ports    : clk - system clock, rising edge                             |
// |            rst - synchronous, active-low reset                         |
// |            bus - uart_tx_if.slave (request inputs, tx_out, busy)       |
// | Macro    : UART_TX_PARITY_EN - when defined, the PARITY state and the  |
// |            par_en/par_typ handling are built; otherwise frames are     |
// |            always start + data + stop and par_en/par_typ are ignored.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   uart_tx_if.slave    bus
);

   localparam int                    c_bit_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [c_bit_w-1:0]    c_last_bit = c_bit_w'(DATA_WIDTH - 1);
   localparam logic [PRESCALE_W-1:0] c_presc_1  = PRESCALE_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                r_state, w_state;
   logic [PRESCALE_W-1:0] r_cnt,   w_cnt;
   logic [PRESCALE_W-1:0] r_presc, w_presc;
   logic [c_bit_w-1:0]    r_bit,   w_bit;
   logic [DATA_WIDTH-1:0] r_data,  w_data;
   logic                  r_tx,    w_tx;
   logic                  r_busy,  w_busy;
   logic                  w_load;
   logic [PRESCALE_W-1:0] w_presc_in;

`ifdef UART_TX_PARITY_EN
   logic r_par_en,  w_par_en;
   logic r_par_bit, w_par_bit;
   logic w_par_in;

   // Parity is resolved at acceptance time so later p_data changes cannot leak in.
   assign w_par_in = bus.par_typ ^ (^bus.p_data);
`else
   logic w_unused_par;
   assign w_unused_par = bus.par_en ^ bus.par_typ;
`endif

   // A prescale of zero behaves as one cycle per bit.
   assign w_presc_in = (bus.prescale == '0) ? c_presc_1 : bus.prescale;

   assign bus.tx_out = r_tx;
   assign bus.busy   = r_busy;

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_presc = r_presc;
      w_bit   = r_bit;
      w_data  = r_data;
      w_tx    = r_tx;
      w_busy  = r_busy;
      w_load  = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_en  = r_par_en;
      w_par_bit = r_par_bit;
`endif

      case (r_state)
         IDLE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            w_load = bus.data_valid;
         end
         START: begin
            if (r_cnt == '0) begin
               w_state = DATA;
               w_cnt   = r_presc - c_presc_1;
               w_bit   = '0;
               w_tx    = r_data[0];
            end else begin
               w_cnt = r_cnt - c_presc_1;
            end
         end
         DATA: begin
            if (r_cnt == '0) begin
               w_cnt = r_presc - c_presc_1;
               if (r_bit == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
                  if (r_par_en) begin
                     w_state = PARITY;
                     w_tx    = r_par_bit;
                  end else begin
                     w_state = STOP;
                     w_tx    = 1'b1;
                  end
`else
                  w_state = STOP;
                  w_tx    = 1'b1;
`endif
               end else begin
                  // Shift register keeps the next bit to send in position 0.
                  w_bit  = r_bit + c_bit_w'(1);
                  w_data = r_data >> 1;
                  w_tx   = w_data[0];
               end
            end else begin
               w_cnt = r_cnt - c_presc_1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (r_cnt == '0) begin
               w_state = STOP;
               w_cnt   = r_presc - c_presc_1;
               w_tx    = 1'b1;
            end else begin
               w_cnt = r_cnt - c_presc_1;
            end
         end
`endif
         STOP: begin
            if (r_cnt == '0) begin
               // A request in the final stop cycle chains straight into a new start bit.
               if (bus.data_valid) begin
                  w_load = 1'b1;
               end else begin
                  w_state = IDLE;
                  w_tx    = 1'b1;
                  w_busy  = 1'b0;
               end
            end else begin
               w_cnt = r_cnt - c_presc_1;
            end
         end
         default: begin
            w_state = IDLE;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
         end
      endcase

      if (w_load) begin
         w_state = START;
         w_presc = w_presc_in;
         w_cnt   = w_presc_in - c_presc_1;
         w_bit   = '0;
         w_data  = bus.p_data;
         w_tx    = 1'b0;
         w_busy  = 1'b1;
`ifdef UART_TX_PARITY_EN
         w_par_en  = bus.par_en;
         w_par_bit = w_par_in;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_presc <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
`endif
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_presc <= w_presc;
         r_bit   <= w_bit;
         r_data  <= w_data;
         r_tx    <= w_tx;
         r_busy  <= w_busy;
`ifdef UART_TX_PARITY_EN
         r_par_en  <= w_par_en;
         r_par_bit <= w_par_bit;
`endif
      end
   end

endmodule
`default_nettype wire
